instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the byte-addressed, combinational-read instruction ROM for the core front end.
//  Holds the fetch PC, drives the ROM address, captures each {pc, instr} pair into a small
//  prefetch queue and hands instructions to decode over a valid/ready handshake.
//  Handles branch/jump redirects (queue flush) and latches a fault on bad fetch addresses.
// PARAMETERS
//  ADDRESS_WIDTH  32   width of PC / ROM address
//  INSTR_WIDTH    32   instruction width
//  ROM_BYTES      4096 ROM size in bytes; legal fetch PC satisfies pc+3 <= ROM_BYTES-1
//  RESET_PC       0    fetch PC loaded on reset
//  QUEUE_DEPTH    2    prefetch entries; power of two, >= 2
// PORTS
//  clk_i            in   1              clock, all state on rising edge
//  rst_i            in   1              synchronous, active-high reset
//  rom_addr_o       out  ADDRESS_WIDTH  byte address to instruction ROM (= fetch PC)
//  rom_data_i       in   INSTR_WIDTH    ROM read data, valid same cycle as rom_addr_o
//  redirect_i       in   1              load new fetch PC, flush queue
//  redirect_pc_i    in   ADDRESS_WIDTH  redirect target
//  instr_valid_o    out  1              head entry valid
//  instr_o          out  INSTR_WIDTH    head instruction
//  instr_pc_o       out  ADDRESS_WIDTH  PC of head instruction
//  instr_ready_i    in   1              decode accepts head this cycle
//  fault_o          out  1              fetch fault latched (misaligned/out-of-range PC)
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, state RUN; instr_valid_o=0, instr_o=0,
//   instr_pc_o=0, fault_o=0, rom_addr_o=RESET_PC. Reset mid-operation discards everything.
//  States: RUN, FAULT. rom_addr_o = fetch_pc in both states.
//  pop  = instr_valid_o & instr_ready_i.
//  push = RUN & !redirect_i & pc_ok(fetch_pc) & (count<QUEUE_DEPTH | pop).
//   push writes {fetch_pc, rom_data_i} at tail; fetch_pc += 4 (mod 2^ADDRESS_WIDTH).
//  pc_ok(p) = p[1:0]==0 & p+3 <= ROM_BYTES-1 (compare at ADDRESS_WIDTH+1 bits, no overflow).
//  RUN & !pc_ok(fetch_pc) & !redirect_i -> FAULT next cycle; no push; queued entries
//   still drain normally. fault_o=1 while in FAULT.
//  Redirect (priority over push and pop; head not consumed even if ready=1):
//   queue count -> 0, fetch_pc <= redirect_pc_i, state <= RUN, fault_o clears.
//   Bad redirect_pc_i is detected on the following cycle via pc_ok -> FAULT.
//  Latency: redirect sampled at edge N -> rom_addr_o=target in cycle N+1 ->
//   instr_valid_o=1 with instr_pc_o=target in cycle N+2. Same 1-cycle fill after reset.
//  Throughput: one instruction/cycle sustained with instr_ready_i=1; simultaneous
//   push+pop when full is legal, count unchanged.
//  Outputs instr_o/instr_pc_o come from the queue head register and are stable while
//   instr_valid_o=1 & instr_ready_i=0. instr_valid_o=0 when count==0. No combinational
//   path from instr_ready_i or redirect_i to any output.
//  Order preserved; no entry delivered twice or dropped except by redirect flush.
// STRUCTURE
//  fetch_pkg: fetch_entry_t struct {pc, instr}; fetch_state_e enum {RUN, FAULT};
//   constant INSTR_BYTES = 4.
//  Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, QUEUE_DEPTH entries, with
//   push/pop/flush, count, head output; flush dominates push/pop.
//  Top holds fetch_pc, state register, pc_ok check, push/pop control.
// TESTING
//  T1 reset, ready=1, ROM words = addr -> instr_pc_o 0x0,0x4,0x8,... one per cycle after
//     1-cycle fill; instr_o matches ROM little-endian word.
//  T2 ready=0 for 5 cycles -> queue holds pc 0x0,0x4; rom_addr_o stalls at 0x8;
//     ready=1 -> 0x0,0x4,0x8 in order, nothing lost or repeated.
//  T3 queue full, redirect to 0x100 with ready=1 -> 0x0/0x4 never accepted after
//     flush; valid=0 for one cycle; instr_pc_o=0x100 two cycles after redirect.
//  T4 redirect to 0x102 -> fault_o=1 next cycle, valid=0, no pushes; redirect to 0x40
//     -> fault_o=0, 0x40 delivered two cycles later.
//  T5 ROM_BYTES=16 from reset -> pcs 0x0,0x4,0x8,0xC delivered, then fault_o=1 with
//     rom_addr_o=0x10; queued entries drain before valid drops.
//  T6 rst_i asserted with full queue and pending ready -> next cycle all outputs at reset
//     values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int FETCH_ADDR_WIDTH  = 32;
    localparam int FETCH_INSTR_WIDTH = 32;
    localparam int INSTR_BYTES       = 4;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0]  pc;
        logic [FETCH_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ROM port plus decode handshake of the fetch controller, bundled as one interface.
interface instr_fetch_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32
);
    logic [ADDRESS_WIDTH-1:0] rom_addr_o;
    logic [INSTR_WIDTH-1:0]   rom_data_i;
    logic                     redirect_i;
    logic [ADDRESS_WIDTH-1:0] redirect_pc_i;
    logic                     instr_valid_o;
    logic [INSTR_WIDTH-1:0]   instr_o;
    logic [ADDRESS_WIDTH-1:0] instr_pc_o;
    logic                     instr_ready_i;
    logic                     fault_o;

    modport master (
        output rom_addr_o, instr_valid_o, instr_o, instr_pc_o, fault_o,
        input  rom_data_i, redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  rom_addr_o, instr_valid_o, instr_o, instr_pc_o, fault_o,
        output rom_data_i, redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} pairs; flush dominates push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t    mem_reg [DEPTH];
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_i) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_i)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset: an entry is only ever read once count covers it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (push_i && !flush_i && wr_ptr_reg == PW'(gi))
                    mem_reg[gi] <= din_i;
            end
        end
    endgenerate

    assign head_o  = mem_reg[rd_ptr_reg];
    assign count_o = count_reg;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch PC sequencing, prefetch queue control, redirect flush and fetch-fault latch.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                     INSTR_WIDTH   = FETCH_INSTR_WIDTH,
    parameter int                     ROM_BYTES     = 4096,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
    parameter int                     QUEUE_DEPTH   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    instr_fetch_ctrl_if.master bus
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e             state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic                     push, pop, pc_good, valid;
    logic [CW-1:0]            count;
    fetch_entry_t             din, head;

    // Word aligned and the whole word inside the ROM; one extra bit avoids wrap.
    function automatic logic pc_ok(input logic [ADDRESS_WIDTH-1:0] p);
        logic [ADDRESS_WIDTH:0] last;
        last = {1'b0, p} + (ADDRESS_WIDTH+1)'(INSTR_BYTES - 1);
        return (p[1:0] == 2'b00) && (last <= (ADDRESS_WIDTH+1)'(ROM_BYTES - 1));
    endfunction

    assign pc_good = pc_ok(fetch_pc_reg);
    assign valid   = (count != '0);
    assign pop     = valid && bus.instr_ready_i && !bus.redirect_i;
    assign push    = (state_reg == RUN) && !bus.redirect_i && pc_good &&
                     ((count < CW'(QUEUE_DEPTH)) || pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= RUN;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (bus.redirect_i) begin
            state_next    = RUN;
            fetch_pc_next = bus.redirect_pc_i;
        end else if (state_reg == RUN && !pc_good) begin
            state_next = FAULT;
        end else if (push) begin
            fetch_pc_next = fetch_pc_reg + ADDRESS_WIDTH'(INSTR_BYTES);
        end
    end

    always_comb begin
        din       = '0;
        din.pc    = FETCH_ADDR_WIDTH'(fetch_pc_reg);
        din.instr = FETCH_INSTR_WIDTH'(bus.rom_data_i);
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_i),
        .din_i   (din),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.rom_addr_o    = fetch_pc_reg;
    assign bus.instr_valid_o = valid;
    assign bus.instr_o       = valid ? INSTR_WIDTH'(head.instr) : '0;
    assign bus.instr_pc_o    = valid ? ADDRESS_WIDTH'(head.pc) : '0;
    assign bus.fault_o       = (state_reg == FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: streaming, stall, redirect, fault, reset.
module tb_instr_fetch_ctrl;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) bus1 ();
    instr_fetch_ctrl_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) bus2 ();

    instr_fetch_ctrl #(.ROM_BYTES(4096)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(bus1.master));
    instr_fetch_ctrl #(.ROM_BYTES(16))   dut2 (.clk_i(clk), .rst_i(rst2), .bus(bus2.master));

    // ROM byte i holds i[7:0]; words are assembled little-endian.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    assign bus1.rom_data_i = rom_word(bus1.rom_addr_o);
    assign bus2.rom_data_i = rom_word(bus2.rom_addr_o);

    // {valid, fault, rom_addr, pc, instr}; head fields are zero when valid is expected low.
    function automatic logic [97:0] ex(input logic v, input logic f,
                                       input logic [31:0] ra, input logic [31:0] pc);
        return {v, f, ra, (v ? {pc, rom_word(pc)} : 64'h0)};
    endfunction

    function automatic logic [97:0] obs1();
        return {bus1.instr_valid_o, bus1.fault_o, bus1.rom_addr_o,
                (bus1.instr_valid_o ? {bus1.instr_pc_o, bus1.instr_o} : 64'h0)};
    endfunction

    function automatic logic [97:0] raw1();
        return {bus1.instr_valid_o, bus1.fault_o, bus1.rom_addr_o, bus1.instr_pc_o, bus1.instr_o};
    endfunction

    function automatic logic [97:0] obs2();
        return {bus2.instr_valid_o, bus2.fault_o, bus2.rom_addr_o,
                (bus2.instr_valid_o ? {bus2.instr_pc_o, bus2.instr_o} : 64'h0)};
    endfunction

    function automatic logic [97:0] raw2();
        return {bus2.instr_valid_o, bus2.fault_o, bus2.rom_addr_o, bus2.instr_pc_o, bus2.instr_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        bus1.redirect_i = 1'b0;
        bus1.instr_ready_i = 1'b0;
        step();
        rst1 = 1'b0;
    endtask

    task automatic test_reset();
        logic [97:0] e;
        rst1 = 1'b1;
        bus1.instr_ready_i = 1'b1;
        step();
        e = ex(1'b0, 1'b0, 32'h0, 32'h0);
        vectors++;
        if (raw1() !== e) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", raw1(), e);
        end
        $display("reset_state: obs %h", raw1());
        rst1 = 1'b0;
        step();
        e = ex(1'b1, 1'b0, 32'h4, 32'h0);
        vectors++;
        if (obs1() !== e) begin
            miscompares++;
            $display("FAIL reset_fill: got %h want %h", obs1(), e);
        end
        $display("reset_fill: obs %h", obs1());
    endtask

    task automatic test_stream();
        logic [97:0] e;
        reset1();
        bus1.instr_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            e = ex(1'b1, 1'b0, 32'(4 * k + 4), 32'(4 * k));
            vectors++;
            if (obs1() !== e) begin
                miscompares++;
                $display("FAIL stream[%0d]: got %h want %h", k, obs1(), e);
            end
            $display("stream[%0d]: pc %h instr %h", k, bus1.instr_pc_o, bus1.instr_o);
        end
    endtask

    task automatic test_stall();
        logic [97:0] e;
        reset1();
        for (int k = 0; k < 5; k++) begin
            step();
            e = ex(1'b1, 1'b0, (k == 0) ? 32'h4 : 32'h8, 32'h0);
            vectors++;
            if (obs1() !== e) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h want %h", k, obs1(), e);
            end
            $display("stall[%0d]: rom_addr %h head %h", k, bus1.rom_addr_o, bus1.instr_pc_o);
        end
        bus1.instr_ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            e = ex(1'b1, 1'b0, 32'(4 * k + 8), 32'(4 * k));
            vectors++;
            if (obs1() !== e) begin
                miscompares++;
                $display("FAIL stall_drain[%0d]: got %h want %h", k, obs1(), e);
            end
            $display("stall_drain[%0d]: head %h", k, bus1.instr_pc_o);
        end
    endtask

    task automatic test_redirect_and_fault();
        logic [97:0] e [8];
        logic [31:0] tgt [8];
        logic        rdr [8];
        // T3: redirect to 0x100 from a full queue, then T4: bad target, then recovery.
        rdr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tgt = '{32'h100, 32'h0, 32'h0, 32'h102, 32'h0, 32'h0, 32'h40, 32'h0};
        e[0] = ex(1'b0, 1'b0, 32'h100, 32'h0);
        e[1] = ex(1'b1, 1'b0, 32'h104, 32'h100);
        e[2] = ex(1'b1, 1'b0, 32'h108, 32'h104);
        e[3] = ex(1'b0, 1'b0, 32'h102, 32'h0);
        e[4] = ex(1'b0, 1'b1, 32'h102, 32'h0);
        e[5] = ex(1'b0, 1'b1, 32'h102, 32'h0);
        e[6] = ex(1'b0, 1'b0, 32'h40, 32'h0);
        e[7] = ex(1'b1, 1'b0, 32'h44, 32'h40);
        reset1();
        step();
        step();
        bus1.instr_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus1.redirect_i = rdr[k];
            bus1.redirect_pc_i = tgt[k];
            step();
            bus1.redirect_i = 1'b0;
            vectors++;
            if (obs1() !== e[k]) begin
                miscompares++;
                $display("FAIL redirect[%0d]: got %h want %h", k, obs1(), e[k]);
            end
            $display("redirect[%0d]: valid %b fault %b rom_addr %h head %h", k,
                     bus1.instr_valid_o, bus1.fault_o, bus1.rom_addr_o, bus1.instr_pc_o);
        end
    endtask

    task automatic test_rom_end();
        logic [97:0] e [8];
        e[0] = ex(1'b0, 1'b0, 32'h0, 32'h0);
        e[1] = ex(1'b1, 1'b0, 32'h4, 32'h0);
        e[2] = ex(1'b1, 1'b0, 32'h8, 32'h0);
        e[3] = ex(1'b1, 1'b0, 32'h8, 32'h0);
        e[4] = ex(1'b1, 1'b0, 32'hC, 32'h4);
        e[5] = ex(1'b1, 1'b0, 32'h10, 32'h8);
        e[6] = ex(1'b1, 1'b1, 32'h10, 32'hC);
        e[7] = ex(1'b0, 1'b1, 32'h10, 32'h0);
        rst2 = 1'b1;
        bus2.instr_ready_i = 1'b0;
        step();
        vectors++;
        if (raw2() !== e[0]) begin
            miscompares++;
            $display("FAIL rom_end_reset: got %h want %h", raw2(), e[0]);
        end
        $display("rom_end_reset: obs %h", raw2());
        rst2 = 1'b0;
        for (int k = 1; k < 8; k++) begin
            if (k == 4) bus2.instr_ready_i = 1'b1;
            step();
            vectors++;
            if (obs2() !== e[k]) begin
                miscompares++;
                $display("FAIL rom_end[%0d]: got %h want %h", k, obs2(), e[k]);
            end
            $display("rom_end[%0d]: valid %b fault %b rom_addr %h head %h", k,
                     bus2.instr_valid_o, bus2.fault_o, bus2.rom_addr_o, bus2.instr_pc_o);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [97:0] e;
        reset1();
        step();
        step();
        step();
        bus1.instr_ready_i = 1'b1;
        rst1 = 1'b1;
        step();
        e = ex(1'b0, 1'b0, 32'h0, 32'h0);
        vectors++;
        if (raw1() !== e) begin
            miscompares++;
            $display("FAIL reset_full: got %h want %h", raw1(), e);
        end
        $display("reset_full: obs %h", raw1());
        rst1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            e = ex(1'b1, 1'b0, 32'(4 * k + 4), 32'(4 * k));
            vectors++;
            if (obs1() !== e) begin
                miscompares++;
                $display("FAIL reset_restart[%0d]: got %h want %h", k, obs1(), e);
            end
            $display("reset_restart[%0d]: head %h", k, bus1.instr_pc_o);
        end
        bus1.redirect_i = 1'b1;
        bus1.redirect_pc_i = 32'h3;
        step();
        bus1.redirect_i = 1'b0;
        step();
        vectors++;
        if (bus1.fault_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_set: got %b want 1", bus1.fault_o);
        end
        $display("fault_set: fault %b", bus1.fault_o);
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        e = ex(1'b0, 1'b0, 32'h0, 32'h0);
        vectors++;
        if (raw1() !== e) begin
            miscompares++;
            $display("FAIL reset_fault: got %h want %h", raw1(), e);
        end
        $display("reset_fault: obs %h", raw1());
    endtask

    initial begin
        bus1.redirect_i = 1'b0;
        bus1.redirect_pc_i = 32'h0;
        bus1.instr_ready_i = 1'b0;
        bus2.redirect_i = 1'b0;
        bus2.redirect_pc_i = 32'h0;
        bus2.instr_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_and_fault();
        test_rom_end();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
